data_sync_mc: RTL and testbench
===============================

DATA_SYNC_MC -- requirements
Module: data_sync_mc

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, data width per channel.
REQ-002 SHALL have parameter NUM_STAGES, default 2, synchroniser depth; legal values >= 2.
REQ-003 SHALL have parameter NUM_CH, default 4, channel count; legal values 1..16.
REQ-004 SHALL have parameter TOGGLE_MODE, default 0: 0 = capture on rising edge of synchronised enable; 1 = capture on either edge.
REQ-005 SHALL define local CH_W = max(1, clog2(NUM_CH)).
REQ-006 SHALL have port clk  input  1  sole clock; all flops on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port bus_enable  input  NUM_CH  asynchronous per-channel enables.
REQ-009 SHALL have port Unsync_bus  input  NUM_CH*BUS_WIDTH  asynchronous data; channel c at bits [c*BUS_WIDTH +: BUS_WIDTH].
REQ-010 SHALL have port sync_ready  input  1  downstream accept.
REQ-011 SHALL have port clr_overflow  input  1  synchronous clear of all overflow flags.
REQ-012 SHALL have port sync_bus  output  BUS_WIDTH  registered output word.
REQ-013 SHALL have port sync_ch  output  CH_W  source channel of sync_bus.
REQ-014 SHALL have port sync_valid  output  1  sync_bus/sync_ch valid.
REQ-015 SHALL have port enable_pulse  output  NUM_CH  one-cycle registered capture pulse per channel.
REQ-016 SHALL have port overflow  output  NUM_CH  sticky per-channel overwrite flag.

Function
REQ-017 SHALL pass each bus_enable[c] through a NUM_STAGES flop chain; last stage = sen[c]; one further flop holds prev[c].
REQ-018 SHALL form event[c] = sen[c] & ~prev[c] when TOGGLE_MODE=0, sen[c] ^ prev[c] when TOGGLE_MODE=1.
REQ-019 SHALL, on the edge where event[c]=1, load hold[c] from the channel-c slice of Unsync_bus, set pend[c], and set enable_pulse[c] high for exactly that following cycle.
REQ-020 SHALL give latency: bus_enable[c] rises before edge 0, idle output, no contention -> enable_pulse[c] high after edge NUM_STAGES, sync_valid high after edge NUM_STAGES+1.
REQ-021 SHALL treat the output register as empty when sync_valid=0 or (sync_valid & sync_ready).
REQ-022 SHALL, when empty and any pend bit set, load sync_bus=hold[g], sync_ch=g, sync_valid=1 and clear pend[g]; g = first pending channel searching upward (with wrap) from last_grant+1.
REQ-023 SHALL update last_grant to g on each load; last_grant resets to NUM_CH-1 (channel 0 highest first priority).
REQ-024 SHALL drop sync_valid on a handshake (sync_valid & sync_ready) when no pend bit is set.
REQ-025 SHALL hold sync_bus, sync_ch, sync_valid stable while sync_valid=1 and sync_ready=0.
REQ-026 SHALL, on event[c] with pend[c]=1 and channel c not granted that cycle, overwrite hold[c] and set overflow[c].
REQ-027 SHALL, on event[c] in the cycle channel c is granted, output the old hold[c], store new data, leave pend[c]=1, no overflow.
REQ-028 SHALL clear all overflow bits on clr_overflow=1; a same-cycle set on channel c wins for bit c.
REQ-029 SHALL handle events on several channels in one cycle independently; each captures and sets its own pend.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear all sync chains, prev, hold, pend, sync_bus, sync_ch, sync_valid, enable_pulse, overflow to 0 and last_grant to NUM_CH-1.
REQ-031 SHALL discard pending and in-flight data on reset mid-operation; first event after release needs full REQ-020 latency.

Verification
REQ-032 SHALL cover: defaults, sync_ready=1, bus_enable[1] rises with slice1=0xA5 -> enable_pulse[1] one cycle after edge 2, sync_valid after edge 3 with sync_bus=0xA5, sync_ch=1.
REQ-033 SHALL cover: channels 0,2,3 fire same cycle, sync_ready=1 -> outputs ch0, ch2, ch3 on three consecutive cycles; next simultaneous burst of ch0,ch3 -> ch0 then ch3 after pointer at 3 (ch0 first).
REQ-034 SHALL cover: sync_ready=0, ch0 delivers 0x11, then ch0 fires 0x22 and 0x33 -> sync_bus held 0x11, overflow[0]=1; after ready, 0x33 delivered; clr_overflow -> overflow[0]=0.
REQ-035 SHALL cover: TOGGLE_MODE=1, bus_enable[0] toggles 0->1->0 spaced 10 cycles, slice 0x01 then 0x02 -> two words 0x01, 0x02, two enable_pulse[0].
REQ-036 SHALL cover: rst_n low while sync_valid=1 and pend=0b0110 -> all outputs 0 immediately; no word emitted after release without new event.

Source files
------------

// File: rtl/data_sync_mc.sv
// Multi-channel enable-qualified data synchroniser.
// Each channel passes its asynchronous enable through a flop chain. A qualifying
// edge of the synchronised enable captures that channel's data word into a
// per-channel holding register. A round-robin arbiter then drains the pending
// words into a single registered output that uses a valid/ready handshake.
module data_sync_mc #(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TOGGLE_MODE = 0,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH*BUS_WIDTH-1:0] Unsync_bus,
  input  logic                        sync_ready,
  input  logic                        clr_overflow,
  output logic [BUS_WIDTH-1:0]        sync_bus,
  output logic [CH_W-1:0]             sync_ch,
  output logic                        sync_valid,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           overflow
);

  // Enable synchroniser chain; stage 0 samples the asynchronous inputs.
  logic [NUM_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                 sen;
  logic [NUM_CH-1:0]                 prev_q;
  logic [NUM_CH-1:0]                 evt;

  // Per-channel capture storage.
  logic [NUM_CH-1:0][BUS_WIDTH-1:0]  hold_q, hold_d;
  logic [NUM_CH-1:0]                 pend_q, pend_d;
  logic [NUM_CH-1:0]                 ovf_set;
  logic [NUM_CH-1:0]                 overflow_q, overflow_d;
  logic [NUM_CH-1:0]                 enable_pulse_q;

  // Arbiter and output register.
  logic [CH_W-1:0]                   last_grant_q, last_grant_d;
  logic                              grant_vld;
  logic [CH_W-1:0]                   grant_idx;
  logic [31:0]                       cand;
  logic                              out_empty;
  logic                              load;
  logic [BUS_WIDTH-1:0]              sync_bus_q, sync_bus_d;
  logic [CH_W-1:0]                   sync_ch_q, sync_ch_d;
  logic                              sync_valid_q, sync_valid_d;

  assign sen = sync_q[NUM_STAGES-1];

  // Shift enables through the synchroniser and keep one extra stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], bus_enable};
      prev_q <= sen;
    end
  end

  // Capture event: rising edge only, or any edge in toggle mode.
  generate
    if (TOGGLE_MODE != 0) begin : gen_toggle
      assign evt = sen ^ prev_q;
    end else begin : gen_rise
      assign evt = sen & ~prev_q;
    end
  endgenerate

  // Output register can take a new word when idle or when its word leaves this cycle.
  assign out_empty = ~sync_valid_q | sync_ready;
  assign load      = out_empty & grant_vld;

  // Round-robin search for the first pending channel after the last granted one.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = (32'(last_grant_q) + i) % NUM_CH;
      if (!grant_vld && pend_q[cand[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[CH_W-1:0];
      end
    end
  end

  // Per-channel capture, pending and overflow bookkeeping.
  always_comb begin
    hold_d  = hold_q;
    pend_d  = pend_q;
    ovf_set = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      logic granted;
      granted = load && (grant_idx == CH_W'(c));
      if (evt[c]) begin
        hold_d[c] = Unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
      end
      // A channel granted in the same cycle it captures keeps a fresh pending word.
      pend_d[c]  = evt[c] | (pend_q[c] & ~granted);
      ovf_set[c] = evt[c] & pend_q[c] & ~granted;
    end
    // A same-cycle overwrite beats the clear for that channel.
    overflow_d = (clr_overflow ? '0 : overflow_q) | ovf_set;
  end

  // Next state for the output register and arbitration pointer.
  always_comb begin
    sync_bus_d   = sync_bus_q;
    sync_ch_d    = sync_ch_q;
    sync_valid_d = sync_valid_q;
    last_grant_d = last_grant_q;
    if (load) begin
      sync_bus_d   = hold_q[grant_idx];
      sync_ch_d    = grant_idx;
      sync_valid_d = 1'b1;
      last_grant_d = grant_idx;
    end else if (sync_valid_q && sync_ready) begin
      sync_valid_d = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q         <= '0;
      pend_q         <= '0;
      overflow_q     <= '0;
      enable_pulse_q <= '0;
    end else begin
      hold_q         <= hold_d;
      pend_q         <= pend_d;
      overflow_q     <= overflow_d;
      enable_pulse_q <= evt;
    end
  end

  // Output and arbiter pointer registers; pointer resets so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_bus_q   <= '0;
      sync_ch_q    <= '0;
      sync_valid_q <= 1'b0;
      last_grant_q <= CH_W'(NUM_CH - 1);
    end else begin
      sync_bus_q   <= sync_bus_d;
      sync_ch_q    <= sync_ch_d;
      sync_valid_q <= sync_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign sync_bus     = sync_bus_q;
  assign sync_ch      = sync_ch_q;
  assign sync_valid   = sync_valid_q;
  assign enable_pulse = enable_pulse_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_data_sync_mc.sv
// Directed bench for data_sync_mc: default instance plus a toggle-mode instance.
module tb_data_sync_mc;
  localparam int unsigned BW  = 8;
  localparam int unsigned NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default (rising-edge) instance.
  logic [NCH-1:0]    bus_enable;
  logic [NCH*BW-1:0] unsync;
  logic              ready;
  logic              clr;
  logic [BW-1:0]     sbus;
  logic [1:0]        sch;
  logic              svalid;
  logic [NCH-1:0]    pulse;
  logic [NCH-1:0]    ovf;

  // Toggle-mode instance.
  logic [NCH-1:0]    t_en;
  logic [NCH*BW-1:0] t_data;
  logic              t_ready;
  logic              t_clr;
  logic [BW-1:0]     t_bus;
  logic [1:0]        t_ch;
  logic              t_valid;
  logic [NCH-1:0]    t_pulse;
  logic [NCH-1:0]    t_ovf;

  data_sync_mc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_enable   (bus_enable),
    .Unsync_bus   (unsync),
    .sync_ready   (ready),
    .clr_overflow (clr),
    .sync_bus     (sbus),
    .sync_ch      (sch),
    .sync_valid   (svalid),
    .enable_pulse (pulse),
    .overflow     (ovf)
  );

  data_sync_mc #(
    .TOGGLE_MODE (1)
  ) dut_t (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_enable   (t_en),
    .Unsync_bus   (t_data),
    .sync_ready   (t_ready),
    .clr_overflow (t_clr),
    .sync_bus     (t_bus),
    .sync_ch      (t_ch),
    .sync_valid   (t_valid),
    .enable_pulse (t_pulse),
    .overflow     (t_ovf)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus_enable = '0;
    t_en       = '0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Toggle-instance pulse and word counters, sampled mid-cycle.
  logic t_mon = 1'b0;
  int   t_pulse_cnt = 0;
  int   t_word_cnt = 0;
  always @(negedge clk) begin
    if (t_mon) begin
      if (t_pulse[0]) t_pulse_cnt++;
      if (t_valid && t_ready) t_word_cnt++;
    end
  end

  initial begin
    rst_n      = 1'b0;
    bus_enable = '0;
    unsync     = '0;
    ready      = 1'b1;
    clr        = 1'b0;
    t_en       = '0;
    t_data     = '0;
    t_ready    = 1'b1;
    t_clr      = 1'b0;

    // Reset state.
    do_reset();
    check("rst_valid", 32'(svalid), 32'h0);
    check("rst_bus", 32'(sbus), 32'h0);
    check("rst_ch", 32'(sch), 32'h0);
    check("rst_pulse", 32'(pulse), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);

    // Single channel latency: ch1 = 0xA5.
    unsync[1*BW +: BW] = 8'hA5;
    bus_enable[1] = 1'b1;
    tick(2);
    check("lat_pulse_e1", 32'(pulse), 32'h0);
    tick(1);
    check("lat_pulse_e2", 32'(pulse), 32'h2);
    check("lat_valid_e2", 32'(svalid), 32'h0);
    tick(1);
    check("lat_pulse_e3", 32'(pulse), 32'h0);
    check("lat_valid_e3", 32'(svalid), 32'h1);
    check("lat_bus", 32'(sbus), 32'hA5);
    check("lat_ch", 32'(sch), 32'h1);
    tick(1);
    check("lat_drop", 32'(svalid), 32'h0);
    bus_enable[1] = 1'b0;
    tick(5);
    check("fall_no_word", 32'(svalid), 32'h0);

    // Simultaneous burst on ch0, ch2, ch3 from a fresh pointer.
    do_reset();
    unsync = {8'h13, 8'h12, 8'h00, 8'h10};
    bus_enable = 4'b1101;
    tick(3);
    check("burst_pulse", 32'(pulse), 32'hD);
    tick(1);
    check("burst1_ch", 32'(sch), 32'h0);
    check("burst1_bus", 32'(sbus), 32'h10);
    tick(1);
    check("burst2_ch", 32'(sch), 32'h2);
    check("burst2_bus", 32'(sbus), 32'h12);
    tick(1);
    check("burst3_ch", 32'(sch), 32'h3);
    check("burst3_bus", 32'(sbus), 32'h13);
    check("burst3_valid", 32'(svalid), 32'h1);
    tick(1);
    check("burst_end", 32'(svalid), 32'h0);
    bus_enable = '0;
    tick(3);
    unsync = {8'h23, 8'h00, 8'h00, 8'h20};
    bus_enable = 4'b1001;
    tick(4);
    check("wrap1_ch", 32'(sch), 32'h0);
    check("wrap1_bus", 32'(sbus), 32'h20);
    tick(1);
    check("wrap2_ch", 32'(sch), 32'h3);
    check("wrap2_bus", 32'(sbus), 32'h23);

    // Backpressure and overflow on ch0.
    do_reset();
    ready = 1'b0;
    unsync = '0;
    unsync[0 +: BW] = 8'h11;
    bus_enable[0] = 1'b1;
    tick(4);
    check("bp_valid", 32'(svalid), 32'h1);
    check("bp_bus", 32'(sbus), 32'h11);
    bus_enable[0] = 1'b0;
    tick(3);
    unsync[0 +: BW] = 8'h22;
    bus_enable[0] = 1'b1;
    tick(3);
    check("bp_ovf_first", 32'(ovf), 32'h0);
    check("bp_hold_bus", 32'(sbus), 32'h11);
    bus_enable[0] = 1'b0;
    tick(3);
    unsync[0 +: BW] = 8'h33;
    bus_enable[0] = 1'b1;
    tick(3);
    check("bp_ovf_set", 32'(ovf), 32'h1);
    check("bp_hold_bus2", 32'(sbus), 32'h11);
    check("bp_hold_valid", 32'(svalid), 32'h1);
    ready = 1'b1;
    tick(1);
    check("bp_new_bus", 32'(sbus), 32'h33);
    check("bp_new_valid", 32'(svalid), 32'h1);
    tick(1);
    check("bp_drain", 32'(svalid), 32'h0);
    check("bp_ovf_sticky", 32'(ovf), 32'h1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("bp_ovf_clr", 32'(ovf), 32'h0);

    // Toggle mode: rise then fall on ch0, ten cycles apart.
    t_mon = 1'b1;
    t_data[0 +: BW] = 8'h01;
    t_en[0] = 1'b1;
    tick(3);
    check("tg_pulse1", 32'(t_pulse), 32'h1);
    tick(1);
    check("tg_valid1", 32'(t_valid), 32'h1);
    check("tg_bus1", 32'(t_bus), 32'h01);
    tick(6);
    t_data[0 +: BW] = 8'h02;
    t_en[0] = 1'b0;
    tick(3);
    check("tg_pulse2", 32'(t_pulse), 32'h1);
    tick(1);
    check("tg_valid2", 32'(t_valid), 32'h1);
    check("tg_bus2", 32'(t_bus), 32'h02);
    tick(6);
    t_mon = 1'b0;
    check("tg_pulse_cnt", 32'(t_pulse_cnt), 32'd2);
    check("tg_word_cnt", 32'(t_word_cnt), 32'd2);

    // Reset mid-operation with one word out and ch1/ch2 pending.
    do_reset();
    ready = 1'b0;
    unsync = {8'h00, 8'h32, 8'h31, 8'h30};
    bus_enable = 4'b0001;
    tick(4);
    check("mr_valid_pre", 32'(svalid), 32'h1);
    bus_enable = 4'b0111;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_async_valid", 32'(svalid), 32'h0);
    check("mr_async_bus", 32'(sbus), 32'h0);
    check("mr_async_pulse", 32'(pulse), 32'h0);
    bus_enable = '0;
    tick(2);
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("mr_no_word", 32'(svalid), 32'h0);
    end
    unsync[3*BW +: BW] = 8'h3C;
    bus_enable[3] = 1'b1;
    tick(2);
    check("mr_lat_pulse_e1", 32'(pulse), 32'h0);
    tick(1);
    check("mr_lat_pulse_e2", 32'(pulse), 32'h8);
    tick(1);
    check("mr_lat_valid", 32'(svalid), 32'h1);
    check("mr_lat_bus", 32'(sbus), 32'h3C);
    check("mr_lat_ch", 32'(sch), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
